// File: rtl/tiny_dnn_mac_array.sv
// Fixed-point MAC array: F_NUM channels dot a streamed input vector against
// stored weights, then emit saturated, rescaled results one channel per beat.
module tiny_dnn_mac_array #(
  parameter int F_NUM  = 16,
  parameter int F_SIZE = 512,
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int FRAC   = 8,
  parameter int RELU   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write,
  input  logic [$clog2(F_NUM*F_SIZE)-1:0] wa,
  input  logic [DW-1:0]                   wd,
  input  logic                            start,
  input  logic [$clog2(F_SIZE):0]         len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW-1:0]                   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   out_data,
  output logic [$clog2(F_NUM)-1:0]        out_ch,
  output logic                            busy
);

  localparam int CW  = $clog2(F_NUM);
  localparam int IW  = $clog2(F_SIZE);
  localparam int LW  = IW + 1;
  localparam int WAW = $clog2(F_NUM*F_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t state;
  logic [LW-1:0] k, len_q, len_eff;
  logic dcnt, v1, v2, xfer;

  logic signed [DW-1:0]   wmem [F_NUM][F_SIZE];
  logic signed [DW-1:0]   wr   [F_NUM];
  logic signed [DW-1:0]   xd;
  logic signed [2*DW-1:0] prod [F_NUM];
  logic signed [AW-1:0]   acc  [F_NUM];

  logic signed [AW-1:0] shf;
  logic [DW-1:0]        res;

  assign len_eff = (len == '0 || len > LW'(F_SIZE))
                 ? LW'(F_SIZE) : len;
  assign in_ready  = state == RUN;
  assign xfer      = in_valid && in_ready;
  assign busy      = state != IDLE;
  assign out_valid = state == OUT;

  // Weight RAM and datapath registers carry no reset; v1/v2 qualify them.
  always_ff @(posedge clk) begin
    if (write && state == IDLE)
      wmem[wa[WAW-1:IW]][wa[IW-1:0]] <= wd;
    if (xfer) begin
      for (int c = 0; c < F_NUM; c++)
        wr[c] <= wmem[c][k[IW-1:0]];
      xd <= in_data;
    end
    for (int c = 0; c < F_NUM; c++)
      prod[c] <= (2*DW)'(wr[c]) * (2*DW)'(xd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      len_q  <= '0;
      dcnt   <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      out_ch <= '0;
      for (int c = 0; c < F_NUM; c++)
        acc[c] <= '0;
    end else begin
      v1 <= xfer;
      v2 <= v1;
      if (v2)
        for (int c = 0; c < F_NUM; c++)
          acc[c] <= acc[c] + AW'(prod[c]);
      unique case (state)
        IDLE: if (start) begin
          len_q <= len_eff;
          k     <= '0;
          for (int c = 0; c < F_NUM; c++)
            acc[c] <= '0;
          state <= RUN;
        end
        RUN: if (xfer) begin
          k <= k + 1'b1;
          if (k + 1'b1 == len_q) begin
            dcnt  <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= 1'b1;
          if (dcnt) state <= OUT;
        end
        OUT: if (out_ready) begin
          if (out_ch == CW'(F_NUM-1)) begin
            out_ch <= '0;
            state  <= IDLE;
          end else begin
            out_ch <= out_ch + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In range iff every bit above the DW-1 sign bit matches it.
  always_comb begin
    shf = acc[out_ch] >>> FRAC;
    if (&shf[AW-1:DW-1] || ~|shf[AW-1:DW-1])
      res = shf[DW-1:0];
    else if (shf[AW-1])
      res = {1'b1, {(DW-1){1'b0}}};
    else
      res = {1'b0, {(DW-1){1'b1}}};
    if (RELU != 0 && res[DW-1])
      res = '0;
  end

  assign out_data = out_valid ? res : '0;

endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
// Scoreboard bench for tiny_dnn_mac_array: a plain and a ReLU instance run
// in lockstep against an integer reference model.
module tb_tiny_dnn_mac_array;

  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;
  localparam int DW     = 16;
  localparam int CW     = 4;
  localparam int LW     = 10;
  localparam int WAW    = 13;

  logic clk = 1'b0;
  logic reset, write, start, in_valid, out_ready;
  logic [WAW-1:0] wa;
  logic [DW-1:0]  wd, in_data;
  logic [LW-1:0]  len;
  logic in_ready, out_valid, busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic r_in_ready, r_out_valid, r_busy;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] r_out_ch;

  always #5 clk = ~clk;

  tiny_dnn_mac_array u_dut (
    .clk(clk), .reset(reset), .write(write), .wa(wa), .wd(wd),
    .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .busy(busy)
  );

  tiny_dnn_mac_array #(.RELU(1)) u_relu (
    .clk(clk), .reset(reset), .write(write), .wa(wa), .wd(wd),
    .start(start), .len(len), .in_valid(in_valid),
    .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .out_data(r_out_data), .out_ch(r_out_ch), .busy(r_busy)
  );

  typedef struct {
    int d;
    int r;
    int ch;
  } exp_t;

  exp_t exp_q[$];
  int wm [F_NUM][F_SIZE];
  int xs [F_SIZE];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_w(int c, int i, int d);
    @(negedge clk);
    write = 1'b1;
    wa    = WAW'(c*F_SIZE + i);
    wd    = DW'(d);
    wm[c][i] = d;
  endtask

  task automatic wr_end();
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic push_exp(int n);
    for (int c = 0; c < F_NUM; c++) begin
      longint a = 0;
      longint sh;
      exp_t e;
      for (int i = 0; i < n; i++)
        a += longint'(wm[c][i]) * longint'(xs[i]);
      a  = (a <<< 24) >>> 24;
      sh = a >>> 8;
      if (sh > 32767) e.d = 32767;
      else if (sh < -32768) e.d = -32768;
      else e.d = int'(sh);
      e.r  = (e.d < 0) ? 0 : e.d;
      e.ch = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_run(int lenp, int bub, int stl, bit poke,
                        bit ws, int ws_c, int ws_i, int ws_d);
    int n, sent, got, guard;
    bit xf, held;
    longint hd, hc;
    exp_t e;
    n = (lenp == 0 || lenp > F_SIZE) ? F_SIZE : lenp;
    @(negedge clk);
    start = 1'b1;
    len   = LW'(lenp);
    if (ws) begin
      write = 1'b1;
      wa    = WAW'(ws_c*F_SIZE + ws_i);
      wd    = DW'(ws_d);
      wm[ws_c][ws_i] = ws_d;
    end
    @(negedge clk);
    start = 1'b0;
    write = 1'b0;
    chk("busy_run", busy, 1);
    push_exp(n);
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 20000) begin
      in_valid = ($urandom_range(99) >= bub);
      in_data  = DW'(xs[sent]);
      if (poke && sent == 1) begin
        write = 1'b1;
        wa    = WAW'(2*F_SIZE);
        wd    = 16'h1234;
        start = 1'b1;
      end
      #1 xf = in_valid && in_ready;
      @(negedge clk);
      write = 1'b0;
      start = 1'b0;
      if (xf) sent++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 20000) chk("feed_timeout", 1, 0);
    chk("rdy_drop", in_ready, 0);
    chk("busy_drain", busy, 1);
    got   = 0;
    guard = 0;
    held  = 1'b0;
    hd    = 0;
    hc    = 0;
    while (got < F_NUM && guard < 5000) begin
      out_ready = ($urandom_range(99) >= stl);
      if (poke && got == 3) begin
        write = 1'b1;
        wa    = WAW'(2*F_SIZE);
        wd    = 16'h1234;
        start = 1'b1;
      end
      #1;
      if (out_valid) begin
        if (held) begin
          chk("stable_d", out_data, hd);
          chk("stable_ch", out_ch, hc);
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          chk("data", longint'($signed(out_data)), e.d);
          chk("ch", out_ch, e.ch);
          chk("relu", longint'($signed(r_out_data)), e.r);
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = out_data;
          hc   = out_ch;
        end
      end
      @(negedge clk);
      out_ready = 1'b0;
      write     = 1'b0;
      start     = 1'b0;
      guard++;
    end
    if (guard >= 5000) chk("out_timeout", 1, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; start = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    wa = '0; wd = '0; in_data = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < 3; i++) wr_w(c, i, 256);
    wr_end();
    for (int i = 0; i < 3; i++) xs[i] = 512;
    do_run(3, 0, 0, 0, 0, 0, 0, 0);

    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < 4; i++) wr_w(c, i, 0);
    wr_w(5, 0, 32767);
    wr_end();
    for (int i = 0; i < 4; i++) xs[i] = 32767;
    do_run(4, 20, 30, 0, 0, 0, 0, 0);
    wr_w(5, 0, -32767);
    wr_end();
    do_run(4, 20, 30, 0, 0, 0, 0, 0);

    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < F_SIZE; i++) wr_w(c, i, 256);
    wr_end();
    for (int i = 0; i < F_SIZE; i++) xs[i] = 1;
    do_run(0, 0, 0, 0, 0, 0, 0, 0);

    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < 37; i++)
        wr_w(c, i, int'($urandom_range(2047)) - 1024);
    wr_end();
    for (int i = 0; i < F_SIZE; i++)
      xs[i] = int'($urandom_range(2047)) - 1024;
    do_run(37, 30, 40, 0, 0, 0, 0, 0);
    do_run(600, 25, 35, 0, 0, 0, 0, 0);

    do_run(5, 10, 20, 1, 0, 0, 0, 0);
    do_run(5, 10, 20, 0, 0, 0, 0, 0);
    do_run(5, 0, 0, 0, 1, 3, 1, 777);

    for (int c = 0; c < F_NUM; c++)
      for (int i = 0; i < 3; i++) wr_w(c, i, 256);
    wr_end();
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd1;
    repeat (100) @(negedge clk);
    chk("k100_busy", busy, 1);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) xs[i] = 512;
    do_run(3, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
